// File: rtl/pixel_framebuf.sv
// pixel_framebuf: packed-pixel frame buffer with byte-lane writes, 3-stage reads and a clear sequencer.
// Define PIXEL_FRAMEBUF_DOUBLE_BUF_EN for a ping-pong bank pair swapped on rd_vsync.
module pixel_framebuf #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8,
  parameter int WIDTH = 256,
  parameter int HEIGHT = 240,
  parameter int PIX_W = 6,
  parameter int COL_WIDTH = 8,
  parameter int NB_COL = 8,
  parameter logic [PIX_W-1:0] CLR_COLOR = 6'h0F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [X_BITS-1:0] wr_x,
  input  logic [Y_BITS-1:0] wr_y,
  input  logic [PIX_W-1:0]  wr_color,
  input  logic              rd_req,
  input  logic [X_BITS-1:0] rd_x,
  input  logic [Y_BITS-1:0] rd_y,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_color,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_oob,
  input  logic              wr_frame_end,
  input  logic              rd_vsync,
  output logic              swapped
);
  localparam int CB = $clog2(NB_COL);
  localparam int IW = X_BITS + Y_BITS;
  localparam int AW = IW - CB;
  localparam int DW = COL_WIDTH * NB_COL;
`ifdef PIXEL_FRAMEBUF_DOUBLE_BUF_EN
  localparam int AA = AW + 1;
`else
  localparam int AA = AW;
`endif
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_cnt;
  logic r_done, r_oob;
  logic w_busy, w_wb, w_rb, w_woob, w_roob;
  logic [IW-1:0] w_widx, w_ridx;
  logic [NB_COL-1:0] r_we;
  logic [AA-1:0] r_waddr, r_raddr;
  logic [DW-1:0] r_di, r_rdata;
  logic [DW-1:0] r_mem [2**AA];
  logic [1:0] r_rv, r_roob;
  logic [CB-1:0] r_col1, r_col2;
  logic r_rvalid;
  logic [PIX_W-1:0] r_rcolor;

  assign w_widx = {wr_y, wr_x};
  assign w_ridx = {rd_y, rd_x};
  assign w_woob = (32'(wr_x) >= WIDTH) || (32'(wr_y) >= HEIGHT);
  assign w_roob = (32'(rd_x) >= WIDTH) || (32'(rd_y) >= HEIGHT);
  assign w_busy = (r_state == CLEAR);
  assign clr_busy = w_busy;
  assign clr_done = r_done;
  assign wr_oob = r_oob;
  assign rd_valid = r_rvalid;
  assign rd_color = r_rcolor;

  always_comb w_next = (r_state == IDLE) ? (clr_start ? CLEAR : IDLE) : ((r_cnt == LAST) ? IDLE : CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_done <= 1'b0;
      r_oob <= 1'b0;
      r_we <= '0;
      r_waddr <= '0;
      r_di <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_busy ? r_cnt + AW'(1) : '0;
      r_done <= w_busy && (r_cnt == LAST);
      r_oob <= r_oob | (wr_valid && !w_busy && w_woob);
      r_we <= w_busy ? '1 : (wr_valid && !w_woob) ? NB_COL'(1) << w_widx[CB-1:0] : '0;
      r_waddr <= AA'({w_wb, w_busy ? r_cnt : w_widx[IW-1:CB]});
      r_di <= w_busy ? {NB_COL{COL_WIDTH'(CLR_COLOR)}}
                     : DW'(COL_WIDTH'(wr_color)) << (COL_WIDTH * 32'(w_widx[CB-1:0]));
    end
  end

  // read-first: the registered read sees the word before this edge's write lands
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_COL; i++)
      if (r_we[i]) r_mem[r_waddr][i*COL_WIDTH +: COL_WIDTH] <= r_di[i*COL_WIDTH +: COL_WIDTH];
    r_rdata <= r_mem[r_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr <= '0;
      r_rv <= '0;
      r_roob <= '0;
      r_col1 <= '0;
      r_col2 <= '0;
      r_rvalid <= 1'b0;
      r_rcolor <= '0;
    end else begin
      r_raddr <= AA'({w_rb, w_ridx[IW-1:CB]});
      r_rv <= {r_rv[0], rd_req};
      r_roob <= {r_roob[0], w_roob};
      r_col1 <= w_ridx[CB-1:0];
      r_col2 <= r_col1;
      r_rvalid <= r_rv[1];
      r_rcolor <= r_roob[1] ? '0 : PIX_W'(r_rdata >> (COL_WIDTH * 32'(r_col2)));
    end
  end

`ifdef PIXEL_FRAMEBUF_DOUBLE_BUF_EN
  logic r_wbank, r_pend, r_swapped, w_swap;
  assign w_swap = rd_vsync && (r_pend || wr_frame_end) && !w_busy;
  assign w_wb = r_wbank;
  assign w_rb = ~r_wbank;
  assign swapped = r_swapped;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbank <= 1'b0;
      r_pend <= 1'b0;
      r_swapped <= 1'b0;
    end else begin
      r_wbank <= r_wbank ^ w_swap;
      r_pend <= !w_swap && (r_pend || wr_frame_end);
      r_swapped <= w_swap;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, wr_frame_end, rd_vsync};
  assign w_wb = 1'b0;
  assign w_rb = 1'b0;
  assign swapped = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_framebuf.sv
// tb_pixel_framebuf: table, directed and random checks of pixel_framebuf against a pixel-level model.
module tb_pixel_framebuf;
  localparam int XB = 9, YB = 8, W = 256, H = 240, NW = (1 << (XB + YB)) / 8;
  localparam logic [5:0] CLR = 6'h0F;
`ifdef PIXEL_FRAMEBUF_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  logic clk = 0, rst_n = 0, wr_valid = 0, rd_req = 0, clr_start = 0, wr_frame_end = 0, rd_vsync = 0;
  logic [XB-1:0] wr_x = 0, rd_x = 0;
  logic [YB-1:0] wr_y = 0, rd_y = 0;
  logic [5:0] wr_color = 0;
  logic rd_valid, clr_busy, clr_done, wr_oob, swapped;
  logic [5:0] rd_color;
  int checks = 0, errors = 0;
  logic [6:0] m [262144];
  logic mwb, mpend, moob;
  logic dv [4];
  logic [6:0] dc [4];
  typedef struct {int wx; int wy; logic [5:0] wc; int rx; int ry; logic [5:0] exp;} vec_t;
  vec_t tab [9];

  pixel_framebuf #(.X_BITS(XB), .Y_BITS(YB), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_color(rd_color),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .wr_oob(wr_oob),
    .wr_frame_end(wr_frame_end), .rd_vsync(rd_vsync), .swapped(swapped));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  function automatic int pidx(logic b, int x, int y);
    return (int'(b) << 17) | (y << 9) | x;
  endfunction

  function automatic logic inb(int x, int y);
    return x < W && y < H;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic wv, input int wx, input int wy, input logic [5:0] wc,
                      input logic rq, input int rx, input int ry, input logic fe, input logic vs);
    logic sw, rb;
    logic [6:0] rc;
    wr_valid = wv; wr_x = XB'(wx); wr_y = YB'(wy); wr_color = wc;
    rd_req = rq; rd_x = XB'(rx); rd_y = YB'(ry); wr_frame_end = fe; rd_vsync = vs;
    rb = DB ? ~mwb : mwb;
    rc = (rq && inb(rx, ry)) ? m[pidx(rb, rx, ry)] : 7'h0;
    if (wv) begin
      if (inb(wx, wy)) m[pidx(mwb, wx, wy)] = {1'b0, wc};
      else moob = 1'b1;
    end
    sw = DB && vs && (mpend || fe);
    mpend = DB && !sw && (mpend || fe);
    mwb = mwb ^ sw;
    @(posedge clk); #1;
    dv[3] = dv[2]; dc[3] = dc[2]; dv[2] = dv[1]; dc[2] = dc[1]; dv[1] = rq; dc[1] = rc;
    chk("rd_valid", rd_valid, dv[3]);
    if (dv[3] && !dc[3][6]) chk("rd_color", rd_color, dc[3][5:0]);
    chk("swapped", swapped, sw);
    chk("wr_oob", wr_oob, moob);
    chk("clr_done_idle", clr_done, 0);
    chk("clr_busy_idle", clr_busy, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int x, input int y, input logic [5:0] c);
    step(1, x, y, c, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int x, input int y);
    step(0, 0, 0, 0, 1, x, y, 0, 0);
  endtask

  task automatic model_reset();
    mwb = 0; mpend = 0; moob = 0;
    for (int i = 1; i < 4; i++) begin dv[i] = 0; dc[i] = 0; end
  endtask

  task automatic do_clear(input logic junk, input logic vs_hold);
    int n;
    logic sawsw;
    repeat (3) idle();
    clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0;
    chk("clr_busy_rise", clr_busy, 1);
    n = 0; sawsw = 0;
    while (clr_busy && n < 4 * NW) begin
      wr_valid = junk & 1'($urandom); wr_x = XB'($urandom); wr_y = YB'($urandom);
      wr_color = 6'($urandom); clr_start = 1'($urandom); rd_vsync = vs_hold;
      @(posedge clk); #1;
      n++;
      sawsw |= swapped;
    end
    wr_valid = 0; clr_start = 0; rd_vsync = 0;
    chk("clr_len", n, NW);
    chk("clr_done_pulse", clr_done, 1);
    chk("swap_in_clear", sawsw, 0);
    for (int y = 0; y < 256; y++)
      for (int x = 0; x < 512; x++) m[pidx(mwb, x, y)] = {1'b0, CLR};
    for (int i = 1; i < 4; i++) dv[i] = 0;
  endtask

  initial begin
    tab[0] = '{20, 10, 6'h3F, 20, 10, 6'h3F};
    tab[1] = '{21, 10, 6'h01, 20, 10, 6'h3F};
    tab[2] = '{255, 239, 6'h22, 255, 239, 6'h22};
    tab[3] = '{256, 0, 6'h11, 256, 0, 6'h00};
    tab[4] = '{0, 240, 6'h11, 0, 240, 6'h00};
    tab[5] = '{0, 239, 6'h07, 0, 239, 6'h07};
    tab[6] = '{31, 100, 6'h30, 30, 100, 6'h0F};
    tab[7] = '{8, 0, 6'h2B, 8, 0, 6'h2B};
    tab[8] = '{7, 0, 6'h2C, 8, 0, 6'h2B};
    for (int i = 0; i < 262144; i++) m[i] = 7'h40;
    model_reset();
    clr_start = 1; rd_req = 1; wr_valid = 1; wr_x = 9'd300;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_color", rd_color, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_wr_oob", wr_oob, 0);
    chk("rst_swapped", swapped, 0);
    clr_start = 0; rd_req = 0; wr_valid = 0; wr_x = 0;
    rst_n = 1;
    idle();

    wr(0, 0, 6'h33);
    wr(100, 200, 6'h21);
    repeat (3) idle();
    clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("abort_busy_before", clr_busy, 1);
    rst_n = 0;
    #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_done", clr_done, 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    for (int x = 0; x < 8; x++) m[pidx(0, x, 0)] = {1'b0, CLR};
    rd(0, 0);
    rd(100, 200);
    rd(1, 0);
    repeat (4) idle();

    do_clear(1, 0);
    if (DB) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      do_clear(0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      wr(40, 40, 6'h2D);
      rd(40, 40);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (2) idle();
      step(0, 0, 0, 0, 1, 40, 40, 0, 1);
      rd(40, 40);
      repeat (3) idle();
    end

    wr(5, 3, 6'h2A);
    idle();
    rd(5, 3);
    rd(4, 3);
    repeat (3) idle();
    step(1, 10, 7, 6'h15, 1, 10, 7, 0, 0);
    rd(10, 7);
    step(1, 11, 7, 6'h16, 1, 11, 7, 0, 0);
    rd(11, 7);
    repeat (3) idle();
    wr(300, 3, 6'h3C);
    rd(300, 3);
    rd(5, 245);
    repeat (3) idle();

    for (int i = 0; i < 9; i++) begin
      wr(tab[i].wx, tab[i].wy, tab[i].wc);
      rd(tab[i].rx, tab[i].ry);
      idle();
      idle();
      if (!DB) chk($sformatf("tab%0d", i), rd_color, tab[i].exp);
    end

    for (int i = 0; i < 3000; i++) begin
      int wx, wy, rx, ry;
      wx = ($urandom % 8 == 0) ? int'($urandom % 512) : int'($urandom % 16);
      wy = ($urandom % 8 == 0) ? int'($urandom % 256) : int'($urandom % 4);
      rx = ($urandom % 8 == 0) ? int'($urandom % 512) : int'($urandom % 16);
      ry = ($urandom % 8 == 0) ? int'($urandom % 256) : int'($urandom % 4);
      step(1'($urandom), wx, wy, 6'($urandom), 1'($urandom), rx, ry,
           $urandom % 16 == 0, $urandom % 8 == 0);
    end
    repeat (3) idle();

    rst_n = 0;
    #1;
    chk("oob_cleared_by_reset", wr_oob, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_framebuf.md
# pixel_framebuf

Parametrised, packed-pixel frame buffer for the NES video path, placed between the PPU pixel stream and the display scan-out. Pixels are packed NB_COL per wide UltraRAM word, one byte-lane column each, so a single pixel write is a single byte-enabled word write. The block has independent write and read ports, a hardware clear sequencer, and an optional ping-pong bank pair for tear-free output.

## Interface
- X_BITS, 8: horizontal coordinate width; line pitch is 2^X_BITS pixels.
- Y_BITS, 8: vertical coordinate width.
- WIDTH, 256: visible pixels per line; must be ≤ 2^X_BITS.
- HEIGHT, 240: visible lines; must be ≤ 2^Y_BITS.
- PIX_W, 6: stored pixel width; must be ≤ COL_WIDTH.
- COL_WIDTH, 8: byte-lane width.
- NB_COL, 8: pixels per word; must be a power of two.
- CLR_COLOR, 6'h0F: colour written by the clear sequencer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  pixel write strobe.
- wr_x  in  X_BITS  write column.
- wr_y  in  Y_BITS  write line.
- wr_color  in  PIX_W  pixel value to write.
- rd_req  in  1  pixel read request.
- rd_x  in  X_BITS  read column.
- rd_y  in  Y_BITS  read line.
- rd_valid  out  1  read data valid.
- rd_color  out  PIX_W  read pixel value.
- clr_start  in  1  pulse; starts a clear of the write bank.
- clr_busy  out  1  clear sequencer active.
- clr_done  out  1  one-cycle pulse when a clear completes.
- wr_oob  out  1  sticky flag: a write fell outside WIDTH×HEIGHT.
- wr_frame_end  in  1  writer finished a frame; requests a bank swap.
- rd_vsync  in  1  reader frame boundary.
- swapped  out  1  one-cycle pulse when the banks swap.

## Operation
- Pixel index is {y, x}. Word address is {bank, index[X_BITS+Y_BITS-1:log2(NB_COL)]}. Column is index[log2(NB_COL)-1:0].
- Storage is COL_WIDTH×NB_COL bits wide. The upper COL_WIDTH−PIX_W bits of each lane are written as 0.
- Write path: a registered single stage drives `we` (one-hot column), the address, and `di` (wr_color placed in the selected lane).
- Writes with x ≥ WIDTH or y ≥ HEIGHT are dropped and set wr_oob. wr_oob clears only on reset.
- Read path:
  - The read address is registered.
  - The RAM output is registered.
  - Lane select and truncation to PIX_W are registered to rd_color.
- A read with x ≥ WIDTH or y ≥ HEIGHT still produces rd_valid, with rd_color = 0.
- The RAM is read-first. On a same-edge read and write to the same word, the read returns the old data.
- FSM IDLE/CLEAR:
  - In IDLE, clr_start moves the FSM to CLEAR with the word counter at 0.
  - In CLEAR, every cycle writes all lanes of word {wbank, counter} with CLR_COLOR, then increments the counter.
  - After the last word (2^(X_BITS+Y_BITS)/NB_COL − 1), the FSM returns to IDLE and pulses clr_done.
- During CLEAR:
  - wr_valid is ignored (pixels dropped, wr_oob unaffected).
  - Reads are serviced normally.
  - clr_start is ignored.
- Reset values:
  - rd_valid, rd_color, clr_busy, clr_done, wr_oob and swapped are 0.
  - The FSM is IDLE, wbank = 0, and swap_pending = 0.
  - RAM contents are not reset.
- Reset asserted mid-clear aborts the clear with no clr_done. Words already cleared stay cleared.

## Timing
- Write accepted at cycle t is committed to the RAM at edge t+1.
- rd_req at cycle t gives rd_valid and rd_color at cycle t+3. One read per cycle, fully pipelined.
- A read at cycle t observes every write accepted at cycle ≤ t−1, and does not observe a write accepted at cycle t.
- clr_busy rises the cycle after clr_start and stays high for exactly 2^(X_BITS+Y_BITS)/NB_COL cycles.
- clr_done pulses in the cycle clr_busy falls.
- Swap:
  - wr_frame_end sets swap_pending.
  - The swap executes on the first cycle with rd_vsync=1, swap_pending=1 and clr_busy=0.
  - On that cycle, wbank toggles, swapped pulses and swap_pending clears.
  - If wr_frame_end and rd_vsync arrive in the same cycle, the swap happens that cycle.
  - The read bank is always ~wbank.

## Configuration
- PIXEL_FRAMEBUF_DOUBLE_BUF_EN defined:
  - The RAM holds two banks, 2×2^(X_BITS+Y_BITS)/NB_COL words.
  - The swap logic is active; the reader sees ~wbank.
- Not defined:
  - Single bank; the bank bit is absent.
  - wr_frame_end and rd_vsync are ignored, swapped is tied to 0, and reads see the write bank.

## Test plan
- Write (x=5,y=3,color=0x2A), then read (5,3) two cycles later: rd_valid at +3, rd_color=0x2A. Neighbouring pixel (4,3) keeps its prior value.
- Write then read the same word in the same cycle: the read returns the old value; a read one cycle later returns 0x2A.
- Write to x=300 with WIDTH=256 under X_BITS=9: the write is dropped and wr_oob=1 until reset. A read there returns 0.
- clr_start with X_BITS=Y_BITS=8, NB_COL=8: clr_busy lasts 8192 cycles, then clr_done pulses. A random read returns 0x0F. PPU writes during the clear are lost.
- Double-buffer enabled:
  - Write frame A to bank 0, then pulse wr_frame_end: no swap until rd_vsync.
  - On rd_vsync, swapped pulses and reads return frame A.
- Assert rst_n low mid-clear: clr_busy=0 immediately, no clr_done, and a fresh clr_start restarts from word 0.
